// File: rtl/instr_fetch_if.sv
// Memory read bus between the instruction fetch unit (master) and the
// instruction memory (slave): request/address out, data/strobe back.
interface instr_fetch_if;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;
    logic        mem_rvalid;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_rdata,
        input  mem_rvalid
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_rdata,
        output mem_rvalid
    );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch unit: accepts a one-cycle start, issues a word-aligned
// read, waits for the memory response and returns the instruction word.
// A fetch that sees no response within WAIT_LIMIT wait edges completes with
// NOP_INSTR and fetch_err set.
// Optional feature: define FETCH_ALIGN_CHECK_EN to reject pc values that are
// not word aligned (no memory request, NOP_INSTR returned, misaligned set).
module instr_fetch #(
    parameter int unsigned WAIT_LIMIT = 16,
    parameter logic [31:0] NOP_INSTR  = 32'h00000013
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [31:0]          pc,
    instr_fetch_if.master        mem,
    output logic [31:0]          instr,
    output logic                 instr_valid,
    output logic                 fetch_done,
    output logic                 busy,
    output logic                 fetch_err,
    output logic                 misaligned
);

`ifdef FETCH_ALIGN_CHECK_EN
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        FAIL = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1
    } state_t;
`endif

    localparam logic [15:0] LIMIT = 16'(WAIT_LIMIT);

    state_t      state_q, state_d;
    logic        mem_req_q, mem_req_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] instr_q, instr_d;
    logic        instr_valid_q, instr_valid_d;
    logic        fetch_done_q, fetch_done_d;
    logic        busy_q, busy_d;
    logic        fetch_err_q, fetch_err_d;
    logic [15:0] wait_cnt_q, wait_cnt_d;
    logic [15:0] wait_cnt_inc;

`ifdef FETCH_ALIGN_CHECK_EN
    logic        misaligned_q, misaligned_d;
`else
    // Low address bits only matter when the alignment check is built in.
    logic        unused_pc_lo;
    assign unused_pc_lo = ^pc[1:0];
`endif

    assign wait_cnt_inc = wait_cnt_q + 16'd1;

    // Next-state and registered-output computation.
    always_comb begin
        state_d       = state_q;
        mem_req_d     = mem_req_q;
        mem_addr_d    = mem_addr_q;
        instr_d       = instr_q;
        instr_valid_d = instr_valid_q;
        fetch_done_d  = 1'b0;
        fetch_err_d   = fetch_err_q;
        wait_cnt_d    = wait_cnt_q;
`ifdef FETCH_ALIGN_CHECK_EN
        misaligned_d  = misaligned_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    mem_addr_d    = {pc[31:2], 2'b00};
                    instr_valid_d = 1'b0;
                    fetch_err_d   = 1'b0;
                    wait_cnt_d    = '0;
`ifdef FETCH_ALIGN_CHECK_EN
                    misaligned_d  = 1'b0;
                    if (pc[1:0] != 2'b00) begin
                        mem_req_d = 1'b0;
                        state_d   = FAIL;
                    end else begin
                        mem_req_d = 1'b1;
                        state_d   = WAIT;
                    end
`else
                    mem_req_d     = 1'b1;
                    state_d       = WAIT;
`endif
                end
            end
            WAIT: begin
                // A response arriving on the limit edge still wins over the abort.
                if (mem.mem_rvalid) begin
                    instr_d       = mem.mem_rdata;
                    instr_valid_d = 1'b1;
                    fetch_done_d  = 1'b1;
                    mem_req_d     = 1'b0;
                    state_d       = IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_inc;
                    if (wait_cnt_inc == LIMIT) begin
                        instr_d       = NOP_INSTR;
                        instr_valid_d = 1'b1;
                        fetch_err_d   = 1'b1;
                        fetch_done_d  = 1'b1;
                        mem_req_d     = 1'b0;
                        state_d       = IDLE;
                    end
                end
            end
`ifdef FETCH_ALIGN_CHECK_EN
            FAIL: begin
                instr_d       = NOP_INSTR;
                instr_valid_d = 1'b1;
                misaligned_d  = 1'b1;
                fetch_done_d  = 1'b1;
                state_d       = IDLE;
            end
`endif
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and output registers, asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            mem_req_q     <= 1'b0;
            mem_addr_q    <= '0;
            instr_q       <= NOP_INSTR;
            instr_valid_q <= 1'b0;
            fetch_done_q  <= 1'b0;
            busy_q        <= 1'b0;
            fetch_err_q   <= 1'b0;
            wait_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            mem_req_q     <= mem_req_d;
            mem_addr_q    <= mem_addr_d;
            instr_q       <= instr_d;
            instr_valid_q <= instr_valid_d;
            fetch_done_q  <= fetch_done_d;
            busy_q        <= busy_d;
            fetch_err_q   <= fetch_err_d;
            wait_cnt_q    <= wait_cnt_d;
        end
    end

`ifdef FETCH_ALIGN_CHECK_EN
    // Alignment-reject flag register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            misaligned_q <= 1'b0;
        end else begin
            misaligned_q <= misaligned_d;
        end
    end
    assign misaligned = misaligned_q;
`else
    assign misaligned = 1'b0;
`endif

    assign mem.mem_req  = mem_req_q;
    assign mem.mem_addr = mem_addr_q;
    assign instr        = instr_q;
    assign instr_valid  = instr_valid_q;
    assign fetch_done   = fetch_done_q;
    assign busy         = busy_q;
    assign fetch_err    = fetch_err_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch (WAIT_LIMIT=4). Expected completions are
// pushed to a scoreboard queue when stimulus is driven and popped when the
// DUT pulses fetch_done. Inputs change and outputs are sampled 1 unit after
// the rising edge.
module tb_instr_fetch;
    localparam logic [31:0] NOP = 32'h00000013;

    typedef struct {
        logic [31:0] instr;
        logic        err;
        logic        mis;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] pc = '0;
    logic [31:0] instr;
    logic        instr_valid;
    logic        fetch_done;
    logic        busy;
    logic        fetch_err;
    logic        misaligned;

    exp_t exp_q[$];
    int   compared   = 0;
    int   mismatched = 0;

    instr_fetch_if mem ();

    instr_fetch #(
        .WAIT_LIMIT (4),
        .NOP_INSTR  (NOP)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .pc          (pc),
        .mem         (mem),
        .instr       (instr),
        .instr_valid (instr_valid),
        .fetch_done  (fetch_done),
        .busy        (busy),
        .fetch_err   (fetch_err),
        .misaligned  (misaligned)
    );

    always #5 clk = ~clk;

    // One-cycle start pulse; returns 1 unit after the accepting edge.
    task automatic start_fetch(input logic [31:0] addr);
        pc    = addr;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Bounded wait for fetch_done; reports edges taken and whether mem_req was seen high.
    task automatic wait_done(input int max_cycles, output bit seen, output int cycles, output bit req_seen);
        seen = 1'b0; cycles = 0; req_seen = 1'b0;
        for (int i = 0; i < max_cycles && !seen; i++) begin
            @(posedge clk); #1;
            cycles++;
            if (mem.mem_req) req_seen = 1'b1;
            if (fetch_done) seen = 1'b1;
        end
    endtask

    task automatic test_reset();
        #2 rst = 1'b0;
        #1;
        compared++; if (mem.mem_req !== 1'b0) begin mismatched++; $display("FAIL reset_mem_req: got %b want 0", mem.mem_req); end
        compared++; if (mem.mem_addr !== 32'h0) begin mismatched++; $display("FAIL reset_mem_addr: got %h want 00000000", mem.mem_addr); end
        compared++; if (instr !== NOP) begin mismatched++; $display("FAIL reset_instr: got %h want %h", instr, NOP); end
        compared++; if ({instr_valid, fetch_done, busy, fetch_err, misaligned} !== 5'b0) begin
            mismatched++; $display("FAIL reset_flags: got %b want 00000", {instr_valid, fetch_done, busy, fetch_err, misaligned});
        end
    endtask

    task automatic test_first_start();
        bit seen, rs; int cyc; exp_t e;
        repeat (2) @(posedge clk);
        pc = 32'h40; start = 1'b1;
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        compared++; if (busy !== 1'b1 || mem.mem_req !== 1'b1 || mem.mem_addr !== 32'h40) begin
            mismatched++; $display("FAIL first_start: busy=%b req=%b addr=%h want 1 1 00000040", busy, mem.mem_req, mem.mem_addr);
        end
        mem.mem_rdata = 32'hA5A5_0001; mem.mem_rvalid = 1'b1;
        exp_q.push_back('{32'hA5A5_0001, 1'b0, 1'b0});
        wait_done(8, seen, cyc, rs);
        mem.mem_rvalid = 1'b0;
        compared++;
        if (!seen) begin mismatched++; $display("FAIL first_start_done: got no fetch_done want pulse"); end
        else begin
            e = exp_q.pop_front();
            if (instr !== e.instr || instr_valid !== 1'b1) begin mismatched++; $display("FAIL first_start_instr: got %h/%b want %h/1", instr, instr_valid, e.instr); end
        end
    endtask

    task automatic test_basic();
        bit seen, rs; int cyc; exp_t e;
        start_fetch(32'h100);
        compared++; if (mem.mem_req !== 1'b1 || mem.mem_addr !== 32'h100 || busy !== 1'b1 || instr_valid !== 1'b0) begin
            mismatched++; $display("FAIL basic_accept: req=%b addr=%h busy=%b valid=%b want 1 00000100 1 0", mem.mem_req, mem.mem_addr, busy, instr_valid);
        end
        mem.mem_rdata = 32'h00500093; mem.mem_rvalid = 1'b1;
        exp_q.push_back('{32'h00500093, 1'b0, 1'b0});
        wait_done(8, seen, cyc, rs);
        mem.mem_rvalid = 1'b0;
        compared++;
        if (!seen || cyc != 1) begin mismatched++; $display("FAIL basic_latency: got seen=%b edges=%0d want 1 edge", seen, cyc); end
        if (seen) begin
            e = exp_q.pop_front();
            compared++; if (instr !== e.instr || instr_valid !== 1'b1 || fetch_err !== e.err || misaligned !== e.mis) begin
                mismatched++; $display("FAIL basic_result: got %h v%b e%b m%b want %h v1 e%b m%b", instr, instr_valid, fetch_err, misaligned, e.instr, e.err, e.mis);
            end
            compared++; if (mem.mem_req !== 1'b0 || busy !== 1'b0) begin mismatched++; $display("FAIL basic_idle: req=%b busy=%b want 0 0", mem.mem_req, busy); end
        end
        @(posedge clk); #1;
        compared++; if (fetch_done !== 1'b0 || instr !== 32'h00500093 || mem.mem_addr !== 32'h100) begin
            mismatched++; $display("FAIL basic_hold: done=%b instr=%h addr=%h want 0 00500093 00000100", fetch_done, instr, mem.mem_addr);
        end
    endtask

    task automatic test_timeout();
        bit seen, rs; int cyc; exp_t e;
        start_fetch(32'h200);
        exp_q.push_back('{NOP, 1'b1, 1'b0});
        wait_done(20, seen, cyc, rs);
        compared++;
        if (!seen || cyc != 4) begin mismatched++; $display("FAIL timeout_edges: got seen=%b edges=%0d want 4 edges", seen, cyc); end
        if (seen) begin
            e = exp_q.pop_front();
            compared++; if (instr !== e.instr || instr_valid !== 1'b1 || fetch_err !== e.err || mem.mem_req !== 1'b0 || busy !== 1'b0) begin
                mismatched++; $display("FAIL timeout_result: got %h v%b e%b req%b busy%b want %h v1 e1 req0 busy0", instr, instr_valid, fetch_err, mem.mem_req, busy, e.instr);
            end
        end
    endtask

    task automatic test_limit_priority();
        bit seen, rs; int cyc; bit early; exp_t e;
        start_fetch(32'h300);
        compared++; if (fetch_err !== 1'b0) begin mismatched++; $display("FAIL err_cleared: got %b want 0", fetch_err); end
        early = 1'b0;
        repeat (3) begin @(posedge clk); #1; if (fetch_done) early = 1'b1; end
        compared++; if (early) begin mismatched++; $display("FAIL limit_early: got fetch_done within 3 wait edges want none"); end
        mem.mem_rdata = 32'hDEADBEEF; mem.mem_rvalid = 1'b1;
        exp_q.push_back('{32'hDEADBEEF, 1'b0, 1'b0});
        wait_done(8, seen, cyc, rs);
        mem.mem_rvalid = 1'b0;
        compared++;
        if (!seen || cyc != 1) begin mismatched++; $display("FAIL limit_done: got seen=%b edges=%0d want 1 edge", seen, cyc); end
        if (seen) begin
            e = exp_q.pop_front();
            compared++; if (instr !== e.instr || fetch_err !== e.err || instr_valid !== 1'b1) begin
                mismatched++; $display("FAIL limit_result: got %h e%b v%b want %h e0 v1", instr, fetch_err, instr_valid, e.instr);
            end
        end
    endtask

    task automatic test_busy_ignore();
        bit seen, rs; int cyc; exp_t e;
        start_fetch(32'h400);
        start_fetch(32'h500);
        compared++; if (mem.mem_addr !== 32'h400 || busy !== 1'b1 || mem.mem_req !== 1'b1) begin
            mismatched++; $display("FAIL busy_ignore_addr: addr=%h busy=%b req=%b want 00000400 1 1", mem.mem_addr, busy, mem.mem_req);
        end
        mem.mem_rdata = 32'h11111111; mem.mem_rvalid = 1'b1;
        exp_q.push_back('{32'h11111111, 1'b0, 1'b0});
        wait_done(8, seen, cyc, rs);
        mem.mem_rvalid = 1'b0;
        compared++;
        if (!seen) begin mismatched++; $display("FAIL busy_ignore_done: got no fetch_done want pulse"); end
        else begin
            e = exp_q.pop_front();
            if (instr !== e.instr) begin mismatched++; $display("FAIL busy_ignore_instr: got %h want %h", instr, e.instr); end
        end
        @(posedge clk); #1;
        compared++; if (busy !== 1'b0 || mem.mem_addr !== 32'h400) begin
            mismatched++; $display("FAIL busy_ignore_latched: busy=%b addr=%h want 0 00000400", busy, mem.mem_addr);
        end
    endtask

    task automatic test_reset_mid();
        bit done_seen;
        start_fetch(32'h600);
        @(posedge clk); #3;
        rst = 1'b0;
        #1;
        compared++; if (mem.mem_req !== 1'b0 || busy !== 1'b0 || instr_valid !== 1'b0 || instr !== NOP) begin
            mismatched++; $display("FAIL reset_mid_abort: req=%b busy=%b valid=%b instr=%h want 0 0 0 %h", mem.mem_req, busy, instr_valid, instr, NOP);
        end
        @(negedge clk) rst = 1'b1;
        mem.mem_rdata = 32'h22222222; mem.mem_rvalid = 1'b1;
        done_seen = 1'b0;
        repeat (3) begin @(posedge clk); #1; if (fetch_done) done_seen = 1'b1; end
        mem.mem_rvalid = 1'b0;
        compared++; if (done_seen || mem.mem_req !== 1'b0 || instr_valid !== 1'b0 || instr !== NOP) begin
            mismatched++; $display("FAIL reset_mid_ignore: done=%b req=%b valid=%b instr=%h want 0 0 0 %h", done_seen, mem.mem_req, instr_valid, instr, NOP);
        end
    endtask

    task automatic test_misalign();
        bit seen, rs; int cyc; exp_t e;
`ifdef FETCH_ALIGN_CHECK_EN
        start_fetch(32'h102);
        compared++; if (mem.mem_req !== 1'b0 || busy !== 1'b1 || misaligned !== 1'b0) begin
            mismatched++; $display("FAIL misalign_accept: req=%b busy=%b mis=%b want 0 1 0", mem.mem_req, busy, misaligned);
        end
        exp_q.push_back('{NOP, 1'b0, 1'b1});
        wait_done(8, seen, cyc, rs);
        compared++;
        if (!seen || cyc != 1 || rs) begin mismatched++; $display("FAIL misalign_done: got seen=%b edges=%0d req_seen=%b want 1 1 0", seen, cyc, rs); end
        if (seen) begin
            e = exp_q.pop_front();
            compared++; if (instr !== e.instr || misaligned !== e.mis || instr_valid !== 1'b1 || fetch_err !== e.err) begin
                mismatched++; $display("FAIL misalign_result: got %h m%b v%b e%b want %h m1 v1 e0", instr, misaligned, instr_valid, fetch_err, e.instr);
            end
        end
        @(posedge clk); #1;
        compared++; if (fetch_done !== 1'b0 || mem.mem_req !== 1'b0) begin mismatched++; $display("FAIL misalign_single: done=%b req=%b want 0 0", fetch_done, mem.mem_req); end
        start_fetch(32'h104);
        compared++; if (misaligned !== 1'b0 || mem.mem_req !== 1'b1) begin mismatched++; $display("FAIL misalign_cleared: mis=%b req=%b want 0 1", misaligned, mem.mem_req); end
        mem.mem_rdata = 32'h44444444; mem.mem_rvalid = 1'b1;
        exp_q.push_back('{32'h44444444, 1'b0, 1'b0});
        wait_done(8, seen, cyc, rs);
        mem.mem_rvalid = 1'b0;
        compared++;
        if (!seen) begin mismatched++; $display("FAIL aligned_after_done: got no fetch_done want pulse"); end
        else begin
            e = exp_q.pop_front();
            if (instr !== e.instr || misaligned !== e.mis) begin mismatched++; $display("FAIL aligned_after_result: got %h m%b want %h m0", instr, misaligned, e.instr); end
        end
`else
        start_fetch(32'h102);
        compared++; if (mem.mem_addr !== 32'h100 || mem.mem_req !== 1'b1 || misaligned !== 1'b0) begin
            mismatched++; $display("FAIL unaligned_accept: addr=%h req=%b mis=%b want 00000100 1 0", mem.mem_addr, mem.mem_req, misaligned);
        end
        mem.mem_rdata = 32'h33333333; mem.mem_rvalid = 1'b1;
        exp_q.push_back('{32'h33333333, 1'b0, 1'b0});
        wait_done(8, seen, cyc, rs);
        mem.mem_rvalid = 1'b0;
        compared++;
        if (!seen || cyc != 1) begin mismatched++; $display("FAIL unaligned_done: got seen=%b edges=%0d want 1 edge", seen, cyc); end
        if (seen) begin
            e = exp_q.pop_front();
            compared++; if (instr !== e.instr || misaligned !== e.mis || instr_valid !== 1'b1) begin
                mismatched++; $display("FAIL unaligned_result: got %h m%b v%b want %h m0 v1", instr, misaligned, instr_valid, e.instr);
            end
        end
`endif
    endtask

    initial begin
        mem.mem_rvalid = 1'b0;
        mem.mem_rdata  = '0;
        test_reset();
        test_first_start();
        test_basic();
        test_timeout();
        test_limit_priority();
        test_busy_ignore();
        test_reset_mid();
        test_misalign();
        compared++;
        if (exp_q.size() != 0) begin mismatched++; $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size()); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
